uart_tx_module: RTL and testbench

- UART transmitter; the counterpart of the existing UART receive path on the FPGA host link.
- Serialises one byte per request as an 8N1 frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Accepts a byte from the accelerator result/readback logic with a start/busy/done handshake.
- Drives the board TX pin directly; the idle line is high.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_band_gen.sv | 40 ++++
 rtl/uart_tx_module.sv | 121 ++++++++++++
 tb/tb_uart_tx_module.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud-divider helper.
// Used by both the transmit and the receive paths of the host link.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // Clock cycles per bit; integer division, so the real rate may be slightly fast.
    function automatic int bps_count(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_band_gen.sv
// Baud tick generator for the UART transmitter: counts 0..BPS_CNT-1 while enabled
// and flags the last cycle of each bit period with bit_end.
module uart_tx_band_gen
    import uart_pkg::*;
#(
    parameter int BPS_CNT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPS_CNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end = enable && (cnt_q == LAST_CNT);

    // Held at zero while disabled so every frame starts a fresh bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_module.sv
// UART 8N1 transmitter: one start bit, eight data bits LSB first, one stop bit.
// The serial line, busy and done flags are all registered.
module uart_tx_module
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data_in,
    output logic       tx_pin_out,
    output logic       tx_busy,
    output logic       tx_done
);

    // Handshake: tx_start is taken on any edge where the FSM is IDLE (tx_busy=0),
    // tx_data_in is sampled on that edge only, tx_busy rises on that same edge and
    // falls on the edge that raises the one-cycle tx_done; requests while busy are dropped.
    localparam int BPS_CNT = bps_count(CLK_FREQ, BAUD_RATE);

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic [2:0]           bit_idx_q;
    logic [2:0]           bit_idx_d;
    logic                 pin_q;
    logic                 pin_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 done_q;
    logic                 done_d;
    logic                 baud_en;
    logic                 bit_end;

    assign baud_en    = (state_q != IDLE);
    assign tx_pin_out = pin_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

    uart_tx_band_gen #(
        .BPS_CNT (BPS_CNT)
    ) u_band_gen (
        .clock   (clock),
        .reset   (reset),
        .enable  (baud_en),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        pin_d     = pin_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                pin_d  = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shreg_d = tx_data_in;
                    state_d = START;
                    pin_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    pin_d     = shreg_q[0];
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        pin_d   = 1'b1;
                    end else begin
                        // Bit 1 of the current register is the next bit on the wire.
                        shreg_d   = shreg_q >> 1;
                        pin_d     = shreg_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            pin_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            pin_q     <= pin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed bench for uart_tx_module at BPS_CNT=10, with a loopback 8N1 receiver model
// that decodes the serial line into rx_q.
module tb_uart_tx_module;

    localparam int BPS = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data_in;
    logic       tx_pin_out;
    logic       tx_busy;
    logic       tx_done;

    int pass_cnt     = 0;
    int chk_cnt      = 0;
    int done_cnt     = 0;
    int overlap_cnt  = 0;
    int rx_cnt       = 0;
    int rx_frame_err = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_tx_module #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_start   (tx_start),
        .tx_data_in (tx_data_in),
        .tx_pin_out (tx_pin_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clock = ~clock;

    // Pre-edge values: counts done pulses and any cycle with done and busy both high.
    always @(posedge clock) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_done === 1'b1 && tx_busy === 1'b1) overlap_cnt++;
    end

    // Loopback receiver: find the start bit, then sample each bit in its middle.
    initial begin : rx_model
        logic [7:0] d;
        d = 8'h00;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && tx_pin_out === 1'b0) begin
                repeat (BPS / 2) @(negedge clock);
                if (tx_pin_out === 1'b0) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (BPS) @(negedge clock);
                        d[k] = tx_pin_out;
                    end
                    repeat (BPS) @(negedge clock);
                    if (tx_pin_out !== 1'b1) rx_frame_err++;
                    rx_q.push_back(d);
                    rx_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic send_start(input logic [7:0] d);
        tx_start   = 1'b1;
        tx_data_in = d;
        tick();
        tx_start   = 1'b0;
    endtask

    // Called on the negedge right after the accepting edge; returns on the tx_done cycle.
    task automatic check_frame(input logic [9:0] exp_bits, input string name);
        logic seen_bad;
        logic act;
        logic busy_bad;
        logic done_bad;
        busy_bad = 1'b0;
        done_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen_bad = 1'b0;
            act      = exp_bits[k];
            for (int s = 0; s < BPS; s++) begin
                if (tx_pin_out !== exp_bits[k]) begin
                    seen_bad = 1'b1;
                    act      = tx_pin_out;
                end
                if (tx_busy !== 1'b1) busy_bad = 1'b1;
                if (tx_done !== 1'b0) done_bad = 1'b1;
                tick();
            end
            chk_cnt++;
            if (seen_bad) $display("FAIL %s_bit%0d: line=%b required=%b", name, k, act, exp_bits[k]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (busy_bad) $display("FAIL %s_busy_in_frame: busy dropped, required 1 for 100 cycles", name);
        else pass_cnt++;
        chk_cnt++;
        if (done_bad) $display("FAIL %s_done_early: done seen, required 0 inside frame", name);
        else pass_cnt++;
        chk_cnt++;
        if (tx_done !== 1'b1) $display("FAIL %s_done_at_100: done=%b required 1", name, tx_done);
        else pass_cnt++;
        chk_cnt++;
        if (tx_busy !== 1'b0) $display("FAIL %s_busy_at_done: busy=%b required 0", name, tx_busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        tx_start   = 1'b0;
        tx_data_in = 8'h00;
        repeat (3) tick();
        chk_cnt++;
        if (tx_pin_out !== 1'b1) $display("FAIL reset_pin: line=%b required 1", tx_pin_out);
        else pass_cnt++;
        chk_cnt++;
        if (tx_busy !== 1'b0) $display("FAIL reset_busy: busy=%b required 0", tx_busy);
        else pass_cnt++;
        chk_cnt++;
        if (tx_done !== 1'b0) $display("FAIL reset_done: done=%b required 0", tx_done);
        else pass_cnt++;
        reset = 1'b1;
        repeat (3) tick();
        chk_cnt++;
        if (tx_pin_out !== 1'b1 || tx_busy !== 1'b0) $display("FAIL idle_after_reset: line=%b busy=%b required 1/0", tx_pin_out, tx_busy);
        else pass_cnt++;
    endtask

    task automatic test_single_frame();
        rx_q.delete();
        send_start(8'hA5);
        // Line order start..stop: 0,1,0,1,0,0,1,0,1,1 (bit 0 is the start bit).
        check_frame(10'b11_0100_1010, "a5");
        tick();
        chk_cnt++;
        if (tx_done !== 1'b0) $display("FAIL a5_done_width: done=%b required 0 one cycle later", tx_done);
        else pass_cnt++;
        chk_cnt++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) $display("FAIL a5_loopback: got %0d bytes first=%h required 1 byte a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] got;
        rx_q.delete();
        send_start(8'h00);
        check_frame({1'b1, 8'h00, 1'b0}, "b2b_00");
        // Request lands in the tx_done cycle; the next start bit follows at the very next edge.
        send_start(8'hFF);
        check_frame({1'b1, 8'hFF, 1'b0}, "b2b_ff");
        tick();
        got = (rx_q.size() == 2) ? {rx_q[0], rx_q[1]} : 16'hxxxx;
        chk_cnt++;
        if (got !== 16'h00FF) $display("FAIL b2b_loopback: got %h (%0d bytes) required 00ff", got, rx_q.size());
        else pass_cnt++;
    endtask

    task automatic test_ignored();
        int   d0;
        logic idle_bad;
        rx_q.delete();
        d0 = done_cnt;
        send_start(8'hC3);
        fork
            check_frame({1'b1, 8'hC3, 1'b0}, "ign_c3");
            begin
                repeat (34) tick();
                tx_start   = 1'b1;
                tx_data_in = 8'h3C;
                tick();
                tx_start   = 1'b0;
                tx_data_in = 8'h99;
            end
        join
        idle_bad = 1'b0;
        repeat (120) begin
            tick();
            if (tx_pin_out !== 1'b1 || tx_busy !== 1'b0) idle_bad = 1'b1;
        end
        chk_cnt++;
        if (idle_bad) $display("FAIL ign_no_queue: line/busy active after frame, required idle");
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL ign_done_count: %0d pulses required 1", done_cnt - d0);
        else pass_cnt++;
        chk_cnt++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hC3) $display("FAIL ign_loopback: got %0d bytes first=%h required 1 byte c3", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int   d0;
        logic idle_bad;
        d0 = done_cnt;
        send_start(8'h55);
        // Data bit 4 occupies cycles 50..59 after the accepting edge.
        repeat (54) tick();
        reset = 1'b0;
        tick();
        chk_cnt++;
        if (tx_pin_out !== 1'b1) $display("FAIL abort_pin: line=%b required 1", tx_pin_out);
        else pass_cnt++;
        chk_cnt++;
        if (tx_busy !== 1'b0) $display("FAIL abort_busy: busy=%b required 0", tx_busy);
        else pass_cnt++;
        reset    = 1'b1;
        idle_bad = 1'b0;
        repeat (110) begin
            tick();
            if (tx_pin_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) idle_bad = 1'b1;
        end
        chk_cnt++;
        if (idle_bad) $display("FAIL abort_stays_idle: frame resumed after reset, required idle");
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt != d0) $display("FAIL abort_no_done: %0d pulses required 0", done_cnt - d0);
        else pass_cnt++;
        rx_q.delete();
        send_start(8'h81);
        check_frame({1'b1, 8'h81, 1'b0}, "post_abort_81");
        tick();
        chk_cnt++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h81) $display("FAIL post_abort_loopback: got %0d bytes first=%h required 1 byte 81", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        else pass_cnt++;
    endtask

    task automatic test_continuous();
        int   t;
        int   lim;
        int   bad;
        logic found;
        int   dt[4];
        rx_q.delete();
        t          = 0;
        tx_start   = 1'b1;
        tx_data_in = 8'h0F;
        for (int n = 0; n < 4; n++) begin
            found = 1'b0;
            lim   = 0;
            while (!found && lim < 150) begin
                tick();
                t++;
                lim++;
                if (tx_done === 1'b1) found = 1'b1;
            end
            dt[n] = found ? t : -1;
        end
        tx_start = 1'b0;
        // First done 100 cycles after the accepting edge (tick 1); each later frame
        // is re-accepted in the done cycle, giving a 101-cycle repeat.
        chk_cnt++;
        if (dt[0] != 101) $display("FAIL cont_first_done: tick %0d required 101", dt[0]);
        else pass_cnt++;
        for (int n = 1; n < 4; n++) begin
            chk_cnt++;
            if (dt[n] < 0 || dt[n] - dt[n-1] != 101) $display("FAIL cont_period%0d: %0d cycles required 101", n, dt[n] - dt[n-1]);
            else pass_cnt++;
        end
        repeat (20) tick();
        chk_cnt++;
        if (tx_busy !== 1'b0) $display("FAIL cont_release: busy=%b required 0 after start dropped", tx_busy);
        else pass_cnt++;
        bad = 0;
        foreach (rx_q[i]) if (rx_q[i] !== 8'h0F) bad++;
        chk_cnt++;
        if (rx_q.size() != 4 || bad != 0) $display("FAIL cont_loopback: %0d bytes %0d wrong required 4 bytes of 0f", rx_q.size(), bad);
        else pass_cnt++;
    endtask

    task automatic test_all_bytes();
        int   r0;
        int   d0;
        int   lim;
        int   timeouts;
        int   bad;
        logic found;
        rx_q.delete();
        exp_q.delete();
        r0       = rx_cnt;
        d0       = done_cnt;
        timeouts = 0;
        for (int b = 0; b < 256; b++) begin
            send_start(8'(b));
            exp_q.push_back(8'(b));
            found = 1'b0;
            lim   = 0;
            while (!found && lim < 150) begin
                tick();
                lim++;
                if (tx_done === 1'b1) found = 1'b1;
            end
            if (!found) begin
                timeouts++;
                break;
            end
        end
        repeat (5) tick();
        chk_cnt++;
        if (timeouts != 0) $display("FAIL all_timeout: tx_done not seen within 150 cycles, required every frame");
        else pass_cnt++;
        chk_cnt++;
        if (rx_q.size() != 256) $display("FAIL all_count: received %0d bytes required 256", rx_q.size());
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL all_data: %0d bytes differ required 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (rx_cnt - r0 != done_cnt - d0) $display("FAIL all_rx_per_done: rx=%0d done=%0d required equal", rx_cnt - r0, done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_invariants();
        chk_cnt++;
        if (overlap_cnt != 0) $display("FAIL done_busy_overlap: %0d cycles required 0", overlap_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (rx_frame_err != 0) $display("FAIL stop_bit: %0d bad stop bits required 0", rx_frame_err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored();
        test_reset_mid_frame();
        test_continuous();
        test_all_bytes();
        test_invariants();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
